lcd_phrase_writer: RTL and testbench
====================================

# lcd_phrase_writer

Parametrised HD44780 4-bit-bus writer that supersedes the fixed 10-character LCD writer: sends a single nibble, a single byte, or a phrase of up to MAX_CHARS bytes, generating the E strobe, setup, gap and execution delays internally from cycle-count parameters. It sits between the LCD sequencer/init FSM and the LCD pins (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). Commands accept on a start/busy handshake, and it adds an extended wait for clear/home commands.

## Interface
- MAX_CHARS, 10: maximum phrase length in bytes (≥1)
- T_SETUP, 2: cycles data/RS are stable before E rises
- T_EN, 12: cycles E is high per nibble
- T_NIB_GAP, 50: cycles E is low between the high and low nibble of a byte (≥1 µs at 50 MHz)
- T_CMD, 2000: cycles waited after each byte or nibble (40 µs)
- T_LONG, 82000: cycles waited instead of T_CMD after clear/home (1.64 ms)
- Clock  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-low reset
- iStart  in  1  request; sampled only in IDLE
- iMode  in  2  0 nibble, 1 byte, 2 phrase, 3 reserved
- iRS  in  1  register select for the whole transfer (0 command, 1 data)
- iData_NIBBLE  in  4  nibble for mode 0
- iData_BYTE  in  8  byte for mode 1
- iData_Phrase  in  8*MAX_CHARS  phrase; byte 0 = bits [7:0] is sent first
- iLength  in  clog2(MAX_CHARS+1)  phrase length; values above MAX_CHARS are clamped to MAX_CHARS
- oBusy  out  1  transfer in progress
- oDone  out  1  one-cycle completion pulse
- oSender  out  4  LCD data nibble
- oEnable  out  1  LCD E
- oRS  out  1  LCD RS
- oRW  out  1  LCD RW, constant 0

## Operation
- **Reset values (asynchronous):** state IDLE, all outputs 0, counters 0, latched data 0.
- **Start acceptance:**
  - In IDLE, iStart=1 latches iMode, iRS, all data inputs and the clamped length.
  - The FSM moves to SETUP_HI, or directly to DONE if mode is 3 or (mode 2 and length 0).
- **States:** IDLE, SETUP_HI, PULSE_HI, GAP, SETUP_LO, PULSE_LO, WAIT, DONE.
  - SETUP_HI (T_SETUP cycles): oSender = high nibble (the nibble itself in mode 0), oEnable=0.
  - PULSE_HI (T_EN cycles): oEnable=1.
  - In mode 0, PULSE_HI goes to WAIT; otherwise it goes to GAP.
  - GAP (T_NIB_GAP cycles): oEnable=0.
  - SETUP_LO (T_SETUP cycles): oSender = low nibble.
  - PULSE_LO (T_EN cycles): oEnable=1.
  - WAIT: lasts T_LONG cycles if oRS=0 and the byte is 8'h01 or 8'h02; otherwise T_CMD cycles. Mode 0 always uses T_CMD.
  - At the end of WAIT in mode 2: if characters remain, shift the phrase right by 8, decrement the remaining count and go to SETUP_HI; otherwise go to DONE.
  - DONE (1 cycle): oDone=1, then IDLE.
- **Output rules during a transfer:**
  - oSender holds the last driven nibble through GAP and WAIT; it is 0 in IDLE and DONE.
  - oRS = latched iRS from SETUP_HI through WAIT; 0 otherwise.
  - oBusy=1 in every state except IDLE.
- **Single timer:** one down-counter, width clog2(max(T_LONG, T_CMD, …)+1). It is loaded on each state entry; the state exits when the counter reaches 0.
- **Input handling:** inputs are ignored while oBusy=1, and input changes after acceptance have no effect.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- iStart is sampled at edge k; oBusy is 1 from cycle k+1.
- Per-byte period P = 2·(T_SETUP+T_EN) + T_NIB_GAP + T_WAIT; with defaults and T_CMD, P = 2078.
- oDone cycle, counting cycles from the first oBusy cycle:
  - mode 1: cycle P
  - mode 2: cycle L·P, where L is the clamped length; bytes run back to back with no idle cycle between them
  - mode 0: cycle T_SETUP+T_EN+T_CMD
  - reserved mode or empty phrase: cycle 0 (DONE immediately)
- Return to IDLE is the cycle after oDone; a new iStart is accepted that same cycle.
- Per-pulse E timing: E high exactly T_EN cycles; oSender and oRS are stable ≥T_SETUP cycles before E rises and ≥T_NIB_GAP or T_CMD cycles after E falls.
- Reset asserted mid-transfer forces oEnable=0 immediately (asynchronously) with no oDone. After Reset deasserts, the first start is accepted on the next edge.

## Test plan
- **Mode 1 byte:** iRS=1, iData_BYTE=8'h41.
  - oSender=4'h4 during the first E pulse and 4'h1 during the second; each E pulse lasts 12 cycles.
  - Gap between pulses: 50 cycles; oRS=1 throughout.
  - oDone at cycle 2078.
- **Mode 2 phrase:** iLength=3, bytes "ABC" (8'h41, 8'h42, 8'h43).
  - Six E pulses carrying nibbles 4,1,4,2,4,3.
  - oDone at cycle 6234; a single oDone pulse.
- **Clear command:** iRS=0, iMode=1, iData_BYTE=8'h01 → WAIT lasts 82000 cycles; oDone at cycle 2·14+50+82000 = 82078.
- **Corner cases:**
  - iMode=3 → oDone pulses in the first busy cycle with no E pulse.
  - iMode=2 with iLength=0 → same immediate oDone with no E pulse.
  - iLength=15 → exactly 10 characters are sent.
- **Mode 0:** iData_NIBBLE=4'h3 → one E pulse with oSender=3; oDone at cycle 2014.
  - iStart pulses while busy are ignored.
  - A back-to-back start on the IDLE-return cycle is accepted.
- **Reset mid-pulse:** assert Reset while oEnable=1 in PULSE_LO.
  - All outputs go to 0 asynchronously; no oDone.
  - After release, a new byte transfer completes normally.

Source files
------------

// File: rtl/lcd_phrase_writer_if.sv
// Request/status handshake and HD44780 4-bit pin bundle between the LCD
// sequencer (master) and lcd_phrase_writer (slave).
interface lcd_phrase_writer_if #(
  parameter int MAX_CHARS = 10
);
  localparam int LW = $clog2(MAX_CHARS + 1);

  logic                   iStart;
  logic [1:0]             iMode;
  logic                   iRS;
  logic [3:0]             iData_NIBBLE;
  logic [7:0]             iData_BYTE;
  logic [8*MAX_CHARS-1:0] iData_Phrase;
  logic [LW-1:0]          iLength;
  logic                   oBusy;
  logic                   oDone;
  logic [3:0]             oSender;
  logic                   oEnable;
  logic                   oRS;
  logic                   oRW;

  modport master (
    output iStart, iMode, iRS, iData_NIBBLE, iData_BYTE, iData_Phrase, iLength,
    input  oBusy, oDone, oSender, oEnable, oRS, oRW
  );

  modport slave (
    input  iStart, iMode, iRS, iData_NIBBLE, iData_BYTE, iData_Phrase, iLength,
    output oBusy, oDone, oSender, oEnable, oRS, oRW
  );
endinterface

// File: rtl/lcd_phrase_writer.sv
// HD44780 4-bit-bus writer: sends a nibble, a byte or a phrase of up to
// MAX_CHARS bytes, timing E strobe, setup, nibble gap and execution waits itself.
module lcd_phrase_writer #(
  parameter int MAX_CHARS = 10,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_NIB_GAP = 50,
  parameter int T_CMD     = 2000,
  parameter int T_LONG    = 82000
) (
  input logic                Clock,
  input logic                Reset,
  lcd_phrase_writer_if.slave bus
);
  localparam int LW    = $clog2(MAX_CHARS + 1);
  localparam int DW    = 8 * MAX_CHARS;
  localparam int M1    = (T_LONG > T_CMD) ? T_LONG : T_CMD;
  localparam int M2    = (M1 > T_NIB_GAP) ? M1 : T_NIB_GAP;
  localparam int M3    = (M2 > T_EN) ? M2 : T_EN;
  localparam int T_MAX = (M3 > T_SETUP) ? M3 : T_SETUP;
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_HI = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_GAP      = 3'd3,
    ST_SETUP_LO = 3'd4,
    ST_PULSE_LO = 3'd5,
    ST_WAIT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            lrs_q, lrs_d;
  logic [DW-1:0]   data_q, data_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [3:0]      sender_q, sender_d;
  logic            en_q, en_d;
  logic            ors_q, ors_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [LW-1:0]   len_clamp_s;
  logic            long_wait_s;
  logic [TW-1:0]   wait_load_s;

  assign len_clamp_s = (bus.iLength > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : bus.iLength;

  // Clear (0x01) and home (0x02) commands need the long execution wait.
  assign long_wait_s = (mode_q != 2'd0) && !lrs_q &&
                       ((data_q[7:0] == 8'h01) || (data_q[7:0] == 8'h02));
  assign wait_load_s = long_wait_s ? TW'(T_LONG - 1) : TW'(T_CMD - 1);

  // State register, transfer context and registered pin outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= 2'd0;
      lrs_q    <= 1'b0;
      data_q   <= '0;
      rem_q    <= '0;
      sender_q <= 4'h0;
      en_q     <= 1'b0;
      ors_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      lrs_q    <= lrs_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      sender_q <= sender_d;
      en_q     <= en_d;
      ors_q    <= ors_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, timer and transfer-context logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    lrs_d   = lrs_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          mode_d = bus.iMode;
          lrs_d  = bus.iRS;
          rem_d  = (bus.iMode == 2'd2) ? len_clamp_s : LW'(1);
          case (bus.iMode)
            2'd0:    data_d = DW'({bus.iData_NIBBLE, 4'h0});
            2'd1:    data_d = DW'(bus.iData_BYTE);
            2'd2:    data_d = bus.iData_Phrase;
            default: data_d = '0;
          endcase
          if ((bus.iMode == 2'd3) || ((bus.iMode == 2'd2) && (len_clamp_s == '0))) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_SETUP_HI;
            cnt_d   = TW'(T_SETUP - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP_HI: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE_HI;
          cnt_d   = TW'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_PULSE_HI: begin
        if (cnt_q == '0) begin
          if (mode_q == 2'd0) begin
            state_d = ST_WAIT;
            cnt_d   = TW'(T_CMD - 1);
          end else begin
            state_d = ST_GAP;
            cnt_d   = TW'(T_NIB_GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_SETUP_LO;
          cnt_d   = TW'(T_SETUP - 1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_SETUP_LO: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE_LO;
          cnt_d   = TW'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_PULSE_LO: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = wait_load_s;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Phrase bytes run back to back: next byte moves into bits [7:0].
          if ((mode_q == 2'd2) && (rem_q > LW'(1))) begin
            state_d = ST_SETUP_HI;
            cnt_d   = TW'(T_SETUP - 1);
            data_d  = data_q >> 4'd8;
            rem_d   = rem_q - LW'(1);
          end else begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are derived from the next state so they register alongside it.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    en_d   = (state_d == ST_PULSE_HI) || (state_d == ST_PULSE_LO);
    case (state_d)
      ST_SETUP_HI: begin
        sender_d = data_d[7:4];
        ors_d    = lrs_d;
      end
      ST_SETUP_LO: begin
        sender_d = data_d[3:0];
        ors_d    = lrs_d;
      end
      ST_PULSE_HI, ST_GAP, ST_PULSE_LO, ST_WAIT: begin
        sender_d = sender_q;
        ors_d    = lrs_d;
      end
      default: begin
        sender_d = 4'h0;
        ors_d    = 1'b0;
      end
    endcase
  end

  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oSender = sender_q;
  assign bus.oEnable = en_q;
  assign bus.oRS     = ors_q;
  assign bus.oRW     = 1'b0;
endmodule

// File: tb/tb_lcd_phrase_writer.sv
// Directed bench for lcd_phrase_writer; T_LONG is shortened so the clear
// command wait stays short, all other timings are the defaults.
module tb_lcd_phrase_writer;
  localparam int MC = 10;
  localparam int LW = $clog2(MC + 1);
  localparam int TS = 2;
  localparam int TE = 12;
  localparam int TG = 50;
  localparam int TC = 2000;
  localparam int TL = 8200;
  localparam int P  = 2 * (TS + TE) + TG + TC;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   npulse, done_cyc, done_cnt, pin_bad, last_chg;
  bit   fin;
  int   rise_c [40];
  int   fall_c [40];
  int   setup_c[40];
  logic [3:0] nib_a[40];
  logic [8*MC-1:0] phr;

  lcd_phrase_writer_if #(.MAX_CHARS(MC)) bus ();

  lcd_phrase_writer #(
    .MAX_CHARS(MC), .T_SETUP(TS), .T_EN(TE), .T_NIB_GAP(TG), .T_CMD(TC), .T_LONG(TL)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one transfer, then records E pulses, done pulses and pin misbehaviour until back in IDLE.
  task automatic run_xfer(input logic [1:0] mode, input logic rs, input logic [3:0] nib,
                          input logic [7:0] byt, input logic [8*MC-1:0] ph,
                          input logic [LW-1:0] len, input int budget, input bit poke);
    logic prev_en;
    logic [3:0] prev_snd;
    int cyc;
    npulse = 0; done_cyc = -1; done_cnt = 0; pin_bad = 0; last_chg = 0; fin = 0;
    prev_en = 1'b0; prev_snd = 4'h0; cyc = 0;
    bus.iMode = mode; bus.iRS = rs; bus.iData_NIBBLE = nib; bus.iData_BYTE = byt;
    bus.iData_Phrase = ph; bus.iLength = len; bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    bus.iMode = ~mode; bus.iRS = ~rs; bus.iData_NIBBLE = ~nib; bus.iData_BYTE = ~byt;
    bus.iData_Phrase = ~ph; bus.iLength = len + LW'(1);
    check_eq("busy_rise", bus.oBusy, 1);
    while (!fin && cyc < budget) begin
      if (bus.oSender != prev_snd) last_chg = cyc;
      if (bus.oEnable && !prev_en && npulse < 40) begin
        rise_c[npulse]  = cyc;
        nib_a[npulse]   = bus.oSender;
        setup_c[npulse] = cyc - last_chg;
      end
      if (!bus.oEnable && prev_en && npulse < 40) begin
        fall_c[npulse] = cyc;
        npulse++;
      end
      if (bus.oDone) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.oBusy && !bus.oDone && bus.oRS !== rs) pin_bad++;
      if ((!bus.oBusy || bus.oDone) && (bus.oRS !== 1'b0 || bus.oSender !== 4'h0)) pin_bad++;
      if (bus.oRW !== 1'b0) pin_bad++;
      if (!bus.oBusy) fin = 1;
      bus.iStart = poke && (cyc == 300 || cyc == 301);
      prev_en  = bus.oEnable;
      prev_snd = bus.oSender;
      if (!fin) begin
        step();
        cyc++;
      end
    end
    bus.iStart = 1'b0;
    check_eq("no_timeout", fin, 1);
    check_eq("pins_ok", pin_bad, 0);
    check_eq("one_done", done_cnt, 1);
  endtask

  initial begin
    bit saw_done;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.iStart = 1'b0; bus.iMode = 2'd0; bus.iRS = 1'b0; bus.iData_NIBBLE = 4'h0;
    bus.iData_BYTE = 8'h00; bus.iData_Phrase = '0; bus.iLength = '0;
    #3;
    check_eq("rst_busy", bus.oBusy, 0);
    check_eq("rst_done", bus.oDone, 0);
    check_eq("rst_en", bus.oEnable, 0);
    check_eq("rst_sender", bus.oSender, 0);
    check_eq("rst_rs", bus.oRS, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Byte 'A' as data: nibbles 4 then 1, 12-cycle pulses, 50-cycle nibble gap.
    run_xfer(2'd1, 1'b1, 4'h0, 8'h41, '0, '0, P + 50, 1'b0);
    check_eq("b_pulses", npulse, 2);
    check_eq("b_nib0", nib_a[0], 4'h4);
    check_eq("b_nib1", nib_a[1], 4'h1);
    check_eq("b_w0", fall_c[0] - rise_c[0], TE);
    check_eq("b_w1", fall_c[1] - rise_c[1], TE);
    check_eq("b_setup0", setup_c[0], TS);
    check_eq("b_setup1", setup_c[1], TS);
    check_eq("b_gap", (rise_c[1] - setup_c[1]) - fall_c[0], TG);
    check_eq("b_done", done_cyc, 2078);

    // Phrase "ABC".
    phr = '0;
    phr[23:0] = 24'h434241;
    run_xfer(2'd2, 1'b1, 4'h0, 8'h00, phr, LW'(3), 3 * P + 50, 1'b0);
    check_eq("p3_pulses", npulse, 6);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("p3_nib%0d", i), nib_a[i], (i % 2 == 0) ? 4'h4 : 4'(1 + i / 2));
    check_eq("p3_b2b", rise_c[2], P + TS);
    check_eq("p3_done", done_cyc, 6234);

    // Clear command takes the long wait; home as data does not.
    run_xfer(2'd1, 1'b0, 4'h0, 8'h01, '0, '0, 2 * (TS + TE) + TG + TL + 50, 1'b0);
    check_eq("clr_pulses", npulse, 2);
    check_eq("clr_nib1", nib_a[1], 4'h1);
    check_eq("clr_done", done_cyc, 2 * (TS + TE) + TG + TL);
    run_xfer(2'd1, 1'b1, 4'h0, 8'h02, '0, '0, TL + 200, 1'b0);
    check_eq("home_data_done", done_cyc, P);

    // Reserved mode and empty phrase finish in the first busy cycle.
    run_xfer(2'd3, 1'b1, 4'h0, 8'h41, '0, LW'(3), 50, 1'b0);
    check_eq("m3_done", done_cyc, 0);
    check_eq("m3_pulses", npulse, 0);
    run_xfer(2'd2, 1'b1, 4'h0, 8'h41, '1, LW'(0), 50, 1'b0);
    check_eq("len0_done", done_cyc, 0);
    check_eq("len0_pulses", npulse, 0);

    // Length 15 clamps to 10 characters "A".."J".
    for (int i = 0; i < MC; i++) phr[8*i +: 8] = 8'(8'h41 + i);
    run_xfer(2'd2, 1'b1, 4'h0, 8'h00, phr, LW'(15), MC * P + 50, 1'b0);
    check_eq("clamp_pulses", npulse, 2 * MC);
    check_eq("clamp_last_nib", nib_a[2 * MC - 1], 4'hA);
    check_eq("clamp_done", done_cyc, MC * P);

    // Nibble mode with iStart pokes while busy, then a back-to-back byte.
    run_xfer(2'd0, 1'b0, 4'h3, 8'hFF, '0, '0, 3000, 1'b1);
    check_eq("nib_pulses", npulse, 1);
    check_eq("nib_val", nib_a[0], 4'h3);
    check_eq("nib_w", fall_c[0] - rise_c[0], TE);
    check_eq("nib_done", done_cyc, 2014);
    run_xfer(2'd1, 1'b1, 4'h0, 8'h5A, '0, '0, P + 50, 1'b0);
    check_eq("b2b_nib0", nib_a[0], 4'h5);
    check_eq("b2b_nib1", nib_a[1], 4'hA);
    check_eq("b2b_done", done_cyc, P);

    // Reset while E is high in the low-nibble pulse.
    bus.iMode = 2'd1; bus.iRS = 1'b1; bus.iData_BYTE = 8'h41; bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < 70; i++) step();
    check_eq("rst_pre_en", bus.oEnable, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_en", bus.oEnable, 0);
    check_eq("arst_busy", bus.oBusy, 0);
    check_eq("arst_sender", bus.oSender, 0);
    check_eq("arst_rs", bus.oRS, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.oDone) saw_done = 1'b1;
    end
    check_eq("arst_no_done", saw_done, 0);
    rst_n = 1'b1;
    run_xfer(2'd1, 1'b1, 4'h0, 8'h42, '0, '0, P + 50, 1'b0);
    check_eq("post_rst_nib1", nib_a[1], 4'h2);
    check_eq("post_rst_done", done_cyc, P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
